dpbram_pingpong_ctrl: RTL and testbench

- Ping-pong controller for one dpbram_core instance: the BRAM is split into two banks.
- An 8-bit valid/ready input stream fills one bank through port 0 while the other, already-full bank drains through port 1 to an 8-bit valid/ready output stream.
- Sits between the AXI-stream ingress and the convolution engine, providing frame-level double buffering with full backpressure.

---
 rtl/dpbram_pingpong_ctrl_pkg.sv | 19 +
 rtl/dpbram_pingpong_ctrl_if.sv | 50 +++++
 rtl/dpbram_pingpong_ctrl_skid_fifo.sv | 51 +++++
 rtl/dpbram_pingpong_ctrl.sv | 144 ++++++++++++++
 tb/tb_dpbram_pingpong_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpbram_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong BRAM controller: data width,
// return-FIFO entry layout and the bank address width helper.
package dpbram_pingpong_ctrl_pkg;

    localparam int DATA_W          = 8;
    localparam int DEFAULT_ADDR_BW = 8;

    // One entry of the read-return FIFO: frame-end marker plus the byte.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Width of the per-bank counter. The top address bit selects the bank.
    function automatic int bank_aw(input int addr_bw);
        return addr_bw - 1;
    endfunction

endpackage

// File: rtl/dpbram_pingpong_ctrl_if.sv
// Bundle of the ingress stream, egress stream and both BRAM ports of the
// ping-pong controller. The slave modport is the controller's view and the
// master modport is the environment's view (stream source/sink and BRAM).
interface dpbram_pingpong_ctrl_if
    import dpbram_pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_BW = DEFAULT_ADDR_BW
);

    logic               i_s_valid;
    logic [DATA_W-1:0]  i_s_data;
    logic               o_s_ready;

    logic               o_m_valid;
    logic [DATA_W-1:0]  o_m_data;
    logic               o_m_last;
    logic               i_m_ready;

    logic               o_w_en_p0;
    logic [ADDR_BW-1:0] o_w_addr_p0;
    logic [DATA_W-1:0]  o_w_data_p0;
    logic               o_r_en_p0;
    logic [ADDR_BW-1:0] o_r_addr_p0;

    logic               o_w_en_p1;
    logic [ADDR_BW-1:0] o_w_addr_p1;
    logic [DATA_W-1:0]  o_w_data_p1;
    logic               o_r_en_p1;
    logic [ADDR_BW-1:0] o_r_addr_p1;
    logic [DATA_W-1:0]  i_r_data_p1;

    logic [1:0]         o_bank_full;

    modport slave (
        input  i_s_valid, i_s_data, i_m_ready, i_r_data_p1,
        output o_s_ready, o_m_valid, o_m_data, o_m_last,
               o_w_en_p0, o_w_addr_p0, o_w_data_p0, o_r_en_p0, o_r_addr_p0,
               o_w_en_p1, o_w_addr_p1, o_w_data_p1, o_r_en_p1, o_r_addr_p1,
               o_bank_full
    );

    modport master (
        output i_s_valid, i_s_data, i_m_ready, i_r_data_p1,
        input  o_s_ready, o_m_valid, o_m_data, o_m_last,
               o_w_en_p0, o_w_addr_p0, o_w_data_p0, o_r_en_p0, o_r_addr_p0,
               o_w_en_p1, o_w_addr_p1, o_w_data_p1, o_r_en_p1, o_r_addr_p1,
               o_bank_full
    );

endinterface

// File: rtl/dpbram_pingpong_ctrl_skid_fifo.sv
// Two-entry return FIFO that absorbs BRAM read data while the output stream
// is stalled. A push and a pop in the same cycle are allowed even when full.
module dpbram_skid_fifo
    import dpbram_pingpong_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        valid,
    output logic [1:0]  occ
);

    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop & (occ != 2'd0);
    assign do_push = push & ((occ != 2'd2) | do_pop);
    assign valid   = (occ != 2'd0);
    assign head    = valid ? mem[rd_ptr] : '0;

    // Storage, pointers and occupancy update on push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/dpbram_pingpong_ctrl.sv
// Frame-level ping-pong controller around a dual-port BRAM. Port 0 fills one
// bank from the input stream while port 1 drains the other, already-full
// bank into the output stream through a small return FIFO.
module dpbram_pingpong_ctrl
    import dpbram_pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_BW   = DEFAULT_ADDR_BW,
    parameter int FRAME_LEN = 128
)
(
    input  logic                   clk,
    input  logic                   reset,
    dpbram_pingpong_ctrl_if.slave  bus
);

    localparam int              CNT_W    = bank_aw(ADDR_BW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [1:0]       bank_full;
    logic [1:0]       set_full;
    logic [1:0]       clr_full;
    logic             inflight;
    logic             last_tag;

    logic             s_ready;
    logic             w_en;
    logic             wr_done;
    logic             pop;
    logic [2:0]       credit;
    logic             issue;
    logic             rd_done;

    logic [1:0]       occ;
    logic             fifo_valid;
    fifo_entry_t      head;
    fifo_entry_t      push_entry;

    // Writer side: accept while the current write bank is not yet full.
    assign s_ready = !bank_full[wr_bank];
    assign w_en    = bus.i_s_valid & s_ready;
    assign wr_done = w_en & (wr_cnt == LAST_CNT);

    // Reader side: only issue a read when the FIFO is guaranteed a free slot
    // for its data, counting the read already in flight and a pop this cycle.
    assign pop     = fifo_valid & bus.i_m_ready;
    assign credit  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = bank_full[rd_bank] & (credit < 3'd2);
    assign rd_done = issue & (rd_cnt == LAST_CNT);

    // Per-bank full flag set/clear requests for this cycle.
    always_comb begin
        set_full = 2'b00;
        clr_full = 2'b00;
        if (wr_done) begin
            set_full[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            clr_full[rd_bank] = 1'b1;
        end
    end

    // Write pointer: walk the bank, then hand it over and switch banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (w_en) begin
            if (wr_done) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Read pointer and in-flight tracking; the bank is released on the edge
    // that samples its last address, since that read has already happened.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bank  <= 1'b0;
            rd_cnt   <= '0;
            inflight <= 1'b0;
            last_tag <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                last_tag <= rd_done;
                if (rd_done) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // Full flags: writer and reader always target different banks here.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full | set_full) & ~clr_full;
        end
    end

    assign push_entry = '{last: last_tag, data: bus.i_r_data_p1};

    dpbram_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .occ       (occ)
    );

    assign bus.o_s_ready   = s_ready;
    assign bus.o_m_valid   = fifo_valid;
    assign bus.o_m_data    = head.data;
    assign bus.o_m_last    = head.last;

    assign bus.o_w_en_p0   = w_en;
    assign bus.o_w_addr_p0 = {wr_bank, wr_cnt};
    assign bus.o_w_data_p0 = bus.i_s_data;
    assign bus.o_r_en_p0   = 1'b0;
    assign bus.o_r_addr_p0 = '0;

    assign bus.o_w_en_p1   = 1'b0;
    assign bus.o_w_addr_p1 = '0;
    assign bus.o_w_data_p1 = '0;
    assign bus.o_r_en_p1   = issue;
    assign bus.o_r_addr_p1 = {rd_bank, rd_cnt};

    assign bus.o_bank_full = bank_full;

endmodule

// File: tb/tb_dpbram_pingpong_ctrl.sv
// Scoreboard bench for the ping-pong controller. Two instances with an 8-byte
// BRAM: FRAME_LEN=4 and FRAME_LEN=3. Both see the same stimulus; sel chooses
// which one is scored. Expected bytes and write addresses are queued at
// stimulus time; a negedge monitor pops and compares.
module tb_dpbram_pingpong_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       sel;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_out   = 0;
    int         stalls  = 0;
    int         bad_addr = 0;
    int         in_idx  = 0;
    int         fl      = 4;
    int         base;

    logic [8:0]  exp_q [$];
    logic [10:0] wr_q  [$];
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_out   = '0;

    dpbram_pingpong_ctrl_if #(.ADDR_BW(3)) b4 ();
    dpbram_pingpong_ctrl_if #(.ADDR_BW(3)) b3 ();

    dpbram_pingpong_ctrl #(.ADDR_BW(3), .FRAME_LEN(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
    dpbram_pingpong_ctrl #(.ADDR_BW(3), .FRAME_LEN(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    always #5 clk = ~clk;

    assign b4.i_s_valid = s_valid;
    assign b4.i_s_data  = s_data;
    assign b4.i_m_ready = m_ready;
    assign b3.i_s_valid = s_valid;
    assign b3.i_s_data  = s_data;
    assign b3.i_m_ready = m_ready;

    // BRAM models: registered read on port 1, write on port 0.
    logic [7:0] mem4 [8];
    logic [7:0] mem3 [8];
    logic [7:0] rd4 = '0;
    logic [7:0] rd3 = '0;
    always @(posedge clk) begin
        if (b4.o_w_en_p0) mem4[b4.o_w_addr_p0] <= b4.o_w_data_p0;
        if (b4.o_r_en_p1) rd4 <= mem4[b4.o_r_addr_p1];
        if (b3.o_w_en_p0) mem3[b3.o_w_addr_p0] <= b3.o_w_data_p0;
        if (b3.o_r_en_p1) rd3 <= mem3[b3.o_r_addr_p1];
    end
    assign b4.i_r_data_p1 = rd4;
    assign b3.i_r_data_p1 = rd3;

    // Selected instance view.
    logic       sr, mv, ml, mw_en, mr_en;
    logic [7:0] md, mw_data;
    logic [2:0] mw_addr;
    logic [1:0] mbf, occ_sel;
    assign sr      = sel ? b3.o_s_ready   : b4.o_s_ready;
    assign mv      = sel ? b3.o_m_valid   : b4.o_m_valid;
    assign md      = sel ? b3.o_m_data    : b4.o_m_data;
    assign ml      = sel ? b3.o_m_last    : b4.o_m_last;
    assign mw_en   = sel ? b3.o_w_en_p0   : b4.o_w_en_p0;
    assign mw_addr = sel ? b3.o_w_addr_p0 : b4.o_w_addr_p0;
    assign mw_data = sel ? b3.o_w_data_p0 : b4.o_w_data_p0;
    assign mr_en   = sel ? b3.o_r_en_p1   : b4.o_r_en_p1;
    assign mbf     = sel ? b3.o_bank_full : b4.o_bank_full;
    assign occ_sel = sel ? dut3.u_fifo.occ : dut4.u_fifo.occ;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: scores output pops, write-port activity and output stability.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("hold_valid", 32'(mv), 32'd1);
                check_output("hold_data", 32'({ml, md}), 32'(prev_out));
            end
            if (mv) check_output("fifo_occ_le2", 32'(occ_sel <= 2'd2), 32'd1);
            if (mv && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL out_extra: got 0x%0h, expected no output", {ml, md});
                end else begin
                    check_output("out_byte", 32'({ml, md}), 32'(exp_q.pop_front()));
                    n_out++;
                end
            end
            if (mw_en) begin
                if (mw_addr[1:0] == 2'b11) bad_addr++;
                if (wr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL wr_extra: got addr %0d, expected no write", mw_addr);
                end else begin
                    check_output("wr_addr_data", 32'({mw_addr, mw_data}), 32'(wr_q.pop_front()));
                end
            end
            prev_stall = mv && !m_ready;
            prev_out   = {ml, md};
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        exp_q.delete();
        wr_q.delete();
        in_idx  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Offer one byte and hold it until accepted; expectations are queued first.
    task automatic apply_stimulus(input logic [7:0] d);
        int t;
        t = 0;
        exp_q.push_back({((in_idx % fl) == fl - 1), d});
        wr_q.push_back({3'((((in_idx / fl) % 2) * 4) + (in_idx % fl)), d});
        in_idx++;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!sr && t < 200) begin
            stalls++;
            t++;
            @(negedge clk);
        end
        if (!sr) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL send_timeout: byte 0x%0h not accepted, required accept within 200 cycles", d);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_output({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_output({name, "_writes"}, 32'(wr_q.size()), 32'd0);
        check_output({name, "_idle"}, 32'(mv), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 300000");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; sel = 1'b0; fl = 4;
        do_reset();

        // Reset state.
        check_output("rst_m_valid", 32'(mv), 32'd0);
        check_output("rst_m_last", 32'(ml), 32'd0);
        check_output("rst_m_data", 32'(md), 32'd0);
        check_output("rst_bank_full", 32'(mbf), 32'd0);
        check_output("rst_s_ready", 32'(sr), 32'd1);
        check_output("rst_enables", 32'({mw_en, mr_en}), 32'd0);

        // Single frame, ready always high: latency and back-to-back output.
        m_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h10 + i));
        @(posedge clk); #1;
        check_output("lat_edge1_valid", 32'(mv), 32'd0);
        @(posedge clk); #1;
        check_output("lat_edge2_valid", 32'(mv), 32'd1);
        check_output("lat_edge2_data", 32'(md), 32'h10);
        repeat (4) @(posedge clk);
        #1;
        check_output("t1_consecutive", 32'(n_out - base), 32'd4);
        wait_drain("t1");

        // Both banks filled while output is stalled.
        do_reset();
        m_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h20 + i));
        check_output("t2_bank_full", 32'(mbf), 32'd3);
        check_output("t2_s_ready", 32'(sr), 32'd0);
        m_ready = 1'b1;
        wait_drain("t2");
        check_output("t2_count", 32'(n_out - base), 32'd8);

        // Five frames streaming at full rate.
        do_reset();
        m_ready = 1'b1;
        stalls = 0;
        base = n_out;
        for (int i = 0; i < 20; i++) apply_stimulus(8'(8'h80 + i));
        check_output("t3_no_stall", 32'(stalls), 32'd0);
        wait_drain("t3");
        check_output("t3_count", 32'(n_out - base), 32'd20);

        // Output ready toggling every cycle over three frames.
        do_reset();
        base = n_out;
        m_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) apply_stimulus(8'(8'hA0 + i));
            end
            begin
                repeat (60) begin
                    @(posedge clk); #1;
                    m_ready = ~m_ready;
                end
            end
        join
        m_ready = 1'b1;
        wait_drain("t4");
        check_output("t4_count", 32'(n_out - base), 32'd12);

        // Reset in the middle of draining frame 1 while frame 2 is partial.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h30 + i));
        m_ready = 1'b1;
        apply_stimulus(8'h40);
        apply_stimulus(8'h41);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_output("t5_m_valid", 32'(mv), 32'd0);
        check_output("t5_bank_full", 32'(mbf), 32'd0);
        check_output("t5_s_ready", 32'(sr), 32'd1);
        for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h50 + i));
        wait_drain("t5");

        // Short frames: bank tail addresses stay untouched.
        sel = 1'b1;
        fl  = 3;
        do_reset();
        m_ready = 1'b1;
        bad_addr = 0;
        base = n_out;
        for (int i = 0; i < 6; i++) apply_stimulus(8'(8'h60 + i));
        wait_drain("t6");
        check_output("t6_bad_addr", 32'(bad_addr), 32'd0);
        check_output("t6_count", 32'(n_out - base), 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
